// File: rtl/wave_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : wave_frame_reader
// Purpose  : Snoops the ADC sampler's buffer write port for the last sample
//            of a capture frame. It then reads the frame back through the
//            buffer's 1-cycle synchronous read port and streams the samples
//            out over valid/ready. While streaming it gathers the per-frame
//            min, max, peak-to-peak and sum.
// Revision : 1.0 - initial release
// ============================================================================
module wave_frame_reader #(
  parameter int FRAME_LEN = 591,
  parameter int ADDR_W    = 12
) (
  input  logic              adc_clk,
  input  logic              rst,           // asynchronous, active-low
  input  logic              adc_buf_wr,
  input  logic [ADDR_W-1:0] adc_buf_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              stats_valid,
  output logic [7:0]        vmax,
  output logic [7:0]        vmin,
  output logic [7:0]        vpp,
  output logic [19:0]       vsum,
  output logic              frame_drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // One readout pass per frame: READ presents the address, LATCH captures
  // the returned data, and OUT holds the sample until it is accepted.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q,       state_d;
  logic [ADDR_W-1:0] rd_addr_q,     rd_addr_d;
  logic [ADDR_W-1:0] idx_q,         idx_d;
  logic [7:0]        out_data_q,    out_data_d;
  logic              out_valid_q,   out_valid_d;
  logic              out_last_q,    out_last_d;
  logic [7:0]        acc_max_q,     acc_max_d;
  logic [7:0]        acc_min_q,     acc_min_d;
  logic [19:0]       acc_sum_q,     acc_sum_d;
  logic              stats_valid_q, stats_valid_d;
  logic [7:0]        vmax_q,        vmax_d;
  logic [7:0]        vmin_q,        vmin_d;
  logic [7:0]        vpp_q,         vpp_d;
  logic [19:0]       vsum_q,        vsum_d;
  logic              frame_drop_q,  frame_drop_d;

  logic              frame_done;

  // A frame is complete when the sampler writes its final address.
  assign frame_done = adc_buf_wr && (adc_buf_addr == LAST_IDX);

  // Next-state and next-output computation for the readout sequencer.
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    idx_d         = idx_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    acc_max_d     = acc_max_q;
    acc_min_d     = acc_min_q;
    acc_sum_d     = acc_sum_q;
    stats_valid_d = 1'b0;
    vmax_d        = vmax_q;
    vmin_d        = vmin_q;
    vpp_d         = vpp_q;
    vsum_d        = vsum_q;
    // A completed frame is lost if a readout pass is still in progress,
    // including the single S_DONE cycle.
    frame_drop_d  = frame_drop_q | (frame_done && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          state_d   = S_READ;
          rd_addr_d = '0;
          idx_d     = '0;
          acc_max_d = 8'h00;
          acc_min_d = 8'hFF;
          acc_sum_d = 20'd0;
        end
      end

      S_READ: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_IDX);
        if (rd_data > acc_max_q) acc_max_d = rd_data;
        if (rd_data < acc_min_q) acc_min_d = rd_data;
        acc_sum_d   = acc_sum_q + {12'd0, rd_data};
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            // Stats become visible in the S_DONE cycle with the pulse.
            state_d       = S_DONE;
            stats_valid_d = 1'b1;
            vmax_d        = acc_max_q;
            vmin_d        = acc_min_q;
            vpp_d         = acc_max_q - acc_min_q;
            vsum_d        = acc_sum_q;
          end else begin
            idx_d     = idx_q + ADDR_ONE;
            rd_addr_d = rd_addr_q + ADDR_ONE;
            state_d   = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any pass in progress.
  always_ff @(posedge adc_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rd_addr_q     <= '0;
      idx_q         <= '0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      acc_max_q     <= 8'h00;
      acc_min_q     <= 8'h00;
      acc_sum_q     <= 20'd0;
      stats_valid_q <= 1'b0;
      vmax_q        <= 8'h00;
      vmin_q        <= 8'h00;
      vpp_q         <= 8'h00;
      vsum_q        <= 20'd0;
      frame_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      idx_q         <= idx_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      acc_max_q     <= acc_max_d;
      acc_min_q     <= acc_min_d;
      acc_sum_q     <= acc_sum_d;
      stats_valid_q <= stats_valid_d;
      vmax_q        <= vmax_d;
      vmin_q        <= vmin_d;
      vpp_q         <= vpp_d;
      vsum_q        <= vsum_d;
      frame_drop_q  <= frame_drop_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign stats_valid = stats_valid_q;
  assign vmax        = vmax_q;
  assign vmin        = vmin_q;
  assign vpp         = vpp_q;
  assign vsum        = vsum_q;
  assign frame_drop  = frame_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_frame_reader
// Purpose  : Bench for wave_frame_reader. It models the sample buffer as an
//            array with a 1-cycle read, and it derives the expected stream
//            and stats directly from the array contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_frame_reader;

  localparam int FRAME_LEN = 591;
  localparam int ADDR_W    = 12;

  logic              adc_clk = 1'b0;
  logic              rst = 1'b0;
  logic              adc_buf_wr = 1'b0;
  logic [ADDR_W-1:0] adc_buf_addr = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              out_last;
  logic              stats_valid;
  logic [7:0]        vmax, vmin, vpp;
  logic [19:0]       vsum;
  logic              frame_drop;

  wave_frame_reader #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .adc_clk     (adc_clk),
    .rst         (rst),
    .adc_buf_wr  (adc_buf_wr),
    .adc_buf_addr(adc_buf_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .stats_valid (stats_valid),
    .vmax        (vmax),
    .vmin        (vmin),
    .vpp         (vpp),
    .vsum        (vsum),
    .frame_drop  (frame_drop)
  );

  always #5 adc_clk = ~adc_clk;

  // Sample buffer with a 1-cycle synchronous read.
  logic [7:0] mem [0:4095];
  always @(posedge adc_clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  // Sink ready: constantly high or a coin flip each cycle.
  bit rand_ready = 1'b0;
  always @(posedge adc_clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: collects accepted beats and stats pulses at the falling edge.
  logic [7:0]  got_data[$];
  bit          got_last[$];
  int          first_cyc, stats_cnt, stats_cyc, valid_seen;
  logic [7:0]  s_max, s_min, s_pp;
  logic [19:0] s_sum;
  bit          stall = 1'b0;
  logic [7:0]  stall_data;

  always @(negedge adc_clk) begin
    if (out_valid) begin
      valid_seen++;
      if (stall) check("stall_stable", out_data, stall_data);
      if (out_ready) begin
        if (got_data.size() == 0) first_cyc = cyc;
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      stall      = !out_ready;
      stall_data = out_data;
    end else begin
      stall = 1'b0;
    end
    if (stats_valid) begin
      stats_cnt++;
      stats_cyc = cyc;
      s_max = vmax; s_min = vmin; s_pp = vpp; s_sum = vsum;
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    stats_cnt  = 0;
    valid_seen = 0;
    first_cyc  = -1;
    stats_cyc  = -1;
  endtask

  // mode 0: ramp k mod 256, 1: constant 0x80, 2: all 0xFF
  task automatic fill(input int mode);
    for (int k = 0; k < FRAME_LEN; k++)
      mem[k] = (mode == 0) ? 8'(k % 256) : (mode == 1) ? 8'h80 : 8'hFF;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_addr"}, rd_addr, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_out_last"}, out_last, 0);
    check({name, "_stats_valid"}, stats_valid, 0);
    check({name, "_vmax"}, vmax, 0);
    check({name, "_vmin"}, vmin, 0);
    check({name, "_vpp"}, vpp, 0);
    check({name, "_vsum"}, vsum, 0);
    check({name, "_frame_drop"}, frame_drop, 0);
  endtask

  // Runs one readout pass and compares it against the buffer contents.
  task automatic run_frame(input string name, input int drop_beat, input int abort_beat,
                           input bit chk_timing, input bit exp_drop);
    int t0;
    bit dropped;
    bit aborted;
    int e_max, e_min, e_sum;
    dropped = 1'b0;
    aborted = 1'b0;
    clear_mon();
    @(posedge adc_clk); #1;
    adc_buf_wr = 1'b1; adc_buf_addr = ADDR_W'(FRAME_LEN - 1); t0 = cyc;
    for (int i = 0; i < 20000; i++) begin
      @(posedge adc_clk); #1;
      adc_buf_wr = 1'b0;
      if (stats_cnt > 0) break;
      if (abort_beat >= 0 && got_data.size() >= abort_beat) begin
        aborted = 1'b1;
        break;
      end
      if (drop_beat >= 0 && !dropped && got_data.size() >= drop_beat) begin
        adc_buf_wr = 1'b1; adc_buf_addr = ADDR_W'(FRAME_LEN - 1); dropped = 1'b1;
      end
    end

    if (aborted) begin
      rst = 1'b0;
      @(negedge adc_clk);
      check_all_zero({name, "_in_reset"});
      repeat (3) @(posedge adc_clk);
      #1 rst = 1'b1;
      repeat (20) @(posedge adc_clk);
      #1;
      check({name, "_no_stats_after_abort"}, stats_cnt, 0);
      return;
    end

    if (stats_cnt == 0) check({name, "_timeout"}, 1, 0);
    repeat (5) @(posedge adc_clk);
    #1;

    e_max = 0; e_min = 255; e_sum = 0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (mem[k] > e_max) e_max = mem[k];
      if (mem[k] < e_min) e_min = mem[k];
      e_sum += mem[k];
    end

    check({name, "_beats"}, got_data.size(), FRAME_LEN);
    for (int k = 0; k < FRAME_LEN && k < got_data.size(); k++) begin
      check({name, "_data"}, got_data[k], mem[k]);
      check({name, "_last"}, got_last[k], (k == FRAME_LEN - 1) ? 1 : 0);
    end
    check({name, "_stats_pulses"}, stats_cnt, 1);
    check({name, "_vmax"}, s_max, e_max);
    check({name, "_vmin"}, s_min, e_min);
    check({name, "_vpp"}, s_pp, e_max - e_min);
    check({name, "_vsum"}, s_sum, e_sum);
    check({name, "_vsum_hold"}, vsum, e_sum);
    check({name, "_vmax_hold"}, vmax, e_max);
    check({name, "_frame_drop"}, frame_drop, exp_drop);
    if (chk_timing) begin
      check({name, "_first_beat_cycle"}, first_cyc, t0 + 3);
      check({name, "_stats_cycle"}, stats_cyc, t0 + 3 + 3 * (FRAME_LEN - 1) + 1);
    end
  endtask

  initial begin
    clear_mon();
    rst = 1'b0;
    repeat (3) @(posedge adc_clk);
    @(negedge adc_clk);
    check_all_zero("reset");
    @(posedge adc_clk); #1 rst = 1'b1;
    repeat (2) @(posedge adc_clk);

    fill(0);
    run_frame("ramp", -1, -1, 1'b1, 1'b0);

    fill(1);
    rand_ready = 1'b1;
    run_frame("const80", -1, -1, 1'b0, 1'b0);
    rand_ready = 1'b0;

    fill(2);
    run_frame("all_ff", -1, -1, 1'b1, 1'b0);

    fill(0);
    run_frame("drop", 100, -1, 1'b1, 1'b1);
    repeat (4) @(posedge adc_clk);
    #1 check("drop_sticky", frame_drop, 1);

    run_frame("abort", -1, 300, 1'b0, 1'b0);
    run_frame("ramp_after_abort", -1, -1, 1'b1, 1'b0);

    // Writes that do not complete a frame must not start a readout.
    clear_mon();
    @(posedge adc_clk); #1;
    adc_buf_wr = 1'b1; adc_buf_addr = ADDR_W'(FRAME_LEN - 2);
    @(posedge adc_clk); #1;
    adc_buf_wr = 1'b0; adc_buf_addr = ADDR_W'(FRAME_LEN - 1);
    @(posedge adc_clk); #1;
    repeat (12) @(posedge adc_clk);
    #1;
    check("no_start_valid", valid_seen, 0);
    check("no_start_stats", stats_cnt, 0);
    check("no_start_drop", frame_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
